// File: rtl/instr_fetch_if.sv
// Instruction-memory read bus between the fetch stage and instruction memory.
// master: drives imem_addr, samples imem_data; slave: the memory side.
interface instr_fetch_if #(
   parameter int ADDR_W = 32
);
   logic [ADDR_W-1:0] imem_addr;
   logic [31:0]       imem_data;

   modport master (
      output imem_addr,
      input  imem_data
   );

   modport slave (
      input  imem_addr,
      output imem_data
   );
endinterface

// File: rtl/instr_fetch.sv
// MIPS fetch stage: owns the PC, reads instruction memory (same-cycle data)
// and fills the IF/ID register. Supports start, stall, redirect and
// end-of-program detection (DONE once the PC walks off the last word).
// Ports: clk, rst_n (async, active-low); start, stall, redirect, redirect_pc;
//   imem (instr_fetch_if.master: imem_addr out = PC, imem_data in);
//   if_id_instr, if_id_pc1, if_id_valid, fetch_done.
// Optional macro INSTR_FETCH_PERF_CNT_EN adds fetch_count, a saturating
//   count of instructions captured into IF/ID.
module instr_fetch #(
   parameter int ADDR_W     = 32,
   parameter int IMEM_DEPTH = 129,
   parameter int RESET_PC   = 0
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic              stall,
   input  logic              redirect,
   input  logic [ADDR_W-1:0] redirect_pc,
   instr_fetch_if.master     imem,
   output logic [31:0]       if_id_instr,
   output logic [ADDR_W-1:0] if_id_pc1,
   output logic              if_id_valid,
`ifdef INSTR_FETCH_PERF_CNT_EN
   output logic [31:0]       fetch_count,
`endif
   output logic              fetch_done
);

   localparam logic [ADDR_W-1:0] DEPTH_C  = ADDR_W'(IMEM_DEPTH);
   localparam logic [ADDR_W-1:0] RST_PC_C = ADDR_W'(RESET_PC);

   typedef enum logic [1:0] {
      S_IDLE,
      S_FETCH,
      S_DONE
   } state_e;

   state_e            state_q, state_d;
   logic [ADDR_W-1:0] pc_q, pc_d;
   logic [31:0]       instr_q, instr_d;
   logic [ADDR_W-1:0] pc1_q, pc1_d;
   logic              valid_q, valid_d;

   logic [ADDR_W-1:0] pc_inc;
   logic              pc_ok;
   logic              rpc_ok;
   logic              capture;

   // Wraps mod 2^ADDR_W; the DONE check stops fetching long before that.
   assign pc_inc = pc_q + {{(ADDR_W-1){1'b0}}, 1'b1};
   assign pc_ok  = (pc_q < DEPTH_C);
   assign rpc_ok = (redirect_pc < DEPTH_C);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         pc_q    <= RST_PC_C;
         instr_q <= '0;
         pc1_q   <= '0;
         valid_q <= 1'b0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         instr_q <= instr_d;
         pc1_q   <= pc1_d;
         valid_q <= valid_d;
      end
   end

   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      instr_d = instr_q;
      pc1_d   = pc1_q;
      valid_d = valid_q;
      capture = 1'b0;
      unique case (state_q)
         S_IDLE: begin
            // IF/ID is left alone; stall has no effect here.
            valid_d = 1'b0;
            if (redirect) begin
               pc_d = redirect_pc;
            end
            if (start) begin
               if (redirect) begin
                  state_d = rpc_ok ? S_FETCH : S_DONE;
               end else begin
                  state_d = pc_ok ? S_FETCH : S_DONE;
               end
            end
         end
         S_FETCH: begin
            if (redirect) begin
               // Flush: the word fetched this cycle is from the wrong path.
               pc_d    = redirect_pc;
               instr_d = '0;
               valid_d = 1'b0;
               state_d = rpc_ok ? S_FETCH : S_DONE;
            end else if (!stall) begin
               capture = 1'b1;
               instr_d = imem.imem_data;
               pc1_d   = pc_inc;
               valid_d = 1'b1;
               pc_d    = pc_inc;
               if (pc_inc == DEPTH_C) begin
                  state_d = S_DONE;
               end
            end
         end
         S_DONE: begin
            // Only an in-range redirect restarts fetching.
            if (redirect && rpc_ok) begin
               pc_d    = redirect_pc;
               instr_d = '0;
               valid_d = 1'b0;
               state_d = S_FETCH;
            end else if (!stall) begin
               valid_d = 1'b0;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

`ifdef INSTR_FETCH_PERF_CNT_EN
   logic [31:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (capture && (cnt_q != 32'hFFFF_FFFF)) begin
         cnt_d = cnt_q + 32'd1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign fetch_count = cnt_q;
`else
   logic unused_capture;
   assign unused_capture = capture;
`endif

   assign imem.imem_addr = pc_q;
   assign if_id_instr    = instr_q;
   assign if_id_pc1      = pc1_q;
   assign if_id_valid    = valid_q;
   assign fetch_done     = (state_q == S_DONE);

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch: a vector table for the main flow plus
// hand-written sequences for end-of-program, DONE redirects and async reset.
module tb_instr_fetch;

   logic        clk;
   logic        rst_n;
   logic        start;
   logic        stall;
   logic        redirect;
   logic [31:0] redirect_pc;
   logic [31:0] if_id_instr;
   logic [31:0] if_id_pc1;
   logic        if_id_valid;
   logic        fetch_done;
`ifdef INSTR_FETCH_PERF_CNT_EN
   logic [31:0] fetch_count;
`endif

   int errors = 0;
   int checks = 0;

   instr_fetch_if #(.ADDR_W(32)) imem ();

   instr_fetch #(
      .ADDR_W(32),
      .IMEM_DEPTH(129),
      .RESET_PC(0)
   ) dut (
      .clk(clk),
      .rst_n(rst_n),
      .start(start),
      .stall(stall),
      .redirect(redirect),
      .redirect_pc(redirect_pc),
      .imem(imem),
      .if_id_instr(if_id_instr),
      .if_id_pc1(if_id_pc1),
      .if_id_valid(if_id_valid),
`ifdef INSTR_FETCH_PERF_CNT_EN
      .fetch_count(fetch_count),
`endif
      .fetch_done(fetch_done)
   );

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      if (a == 32'd0) return 32'h8C01_0001;
      if (a == 32'd1) return 32'h0021_0820;
      return 32'h1000_0000 | a;
   endfunction

   assign imem.imem_data = mem_word(imem.imem_addr);

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_all(input string tag, input logic [31:0] a,
                          input logic [31:0] ins, input logic [31:0] p1,
                          input logic v, input logic d);
      chk({tag, ".addr"}, imem.imem_addr, a);
      chk({tag, ".instr"}, if_id_instr, ins);
      chk({tag, ".pc1"}, if_id_pc1, p1);
      chk({tag, ".valid"}, {31'd0, if_id_valid}, {31'd0, v});
      chk({tag, ".done"}, {31'd0, fetch_done}, {31'd0, d});
   endtask

   typedef struct {
      logic        st;
      logic        sl;
      logic        rd;
      logic [31:0] rpc;
      logic [31:0] e_addr;
      logic [31:0] e_instr;
      logic [31:0] e_pc1;
      logic        e_valid;
      logic        e_done;
   } vec_t;

   vec_t tbl[15];

   initial begin
      tbl[0]  = '{1, 0, 0, 0,   0,   0,             0,  0, 0};
      tbl[1]  = '{0, 0, 0, 0,   1,   32'h8C010001,  1,  1, 0};
      tbl[2]  = '{0, 0, 0, 0,   2,   32'h00210820,  2,  1, 0};
      tbl[3]  = '{0, 0, 0, 0,   3,   mem_word(2),   3,  1, 0};
      tbl[4]  = '{0, 0, 0, 0,   4,   mem_word(3),   4,  1, 0};
      tbl[5]  = '{0, 1, 0, 0,   4,   mem_word(3),   4,  1, 0};
      tbl[6]  = '{0, 1, 0, 0,   4,   mem_word(3),   4,  1, 0};
      tbl[7]  = '{0, 1, 0, 0,   4,   mem_word(3),   4,  1, 0};
      tbl[8]  = '{0, 0, 0, 0,   5,   mem_word(4),   5,  1, 0};
      tbl[9]  = '{0, 0, 0, 0,   6,   mem_word(5),   6,  1, 0};
      tbl[10] = '{0, 1, 1, 10,  10,  0,             6,  0, 0};
      tbl[11] = '{0, 0, 0, 0,   11,  mem_word(10),  11, 1, 0};
      tbl[12] = '{0, 0, 1, 200, 200, 0,             11, 0, 1};
      tbl[13] = '{0, 0, 1, 3,   3,   0,             11, 0, 0};
      tbl[14] = '{0, 0, 0, 0,   4,   mem_word(3),   4,  1, 0};

      rst_n       = 1'b0;
      start       = 1'b0;
      stall       = 1'b0;
      redirect    = 1'b0;
      redirect_pc = '0;
      #2;
      chk_all("reset", 0, 0, 0, 0, 0);
`ifdef INSTR_FETCH_PERF_CNT_EN
      chk("reset.count", fetch_count, 0);
`endif
      #10;
      rst_n = 1'b1;

      for (int i = 0; i < 15; i++) begin
         start       = tbl[i].st;
         stall       = tbl[i].sl;
         redirect    = tbl[i].rd;
         redirect_pc = tbl[i].rpc;
         step();
         chk_all($sformatf("vec%0d", i), tbl[i].e_addr, tbl[i].e_instr,
                 tbl[i].e_pc1, tbl[i].e_valid, tbl[i].e_done);
      end
      start    = 1'b0;
      stall    = 1'b0;
      redirect = 1'b0;
`ifdef INSTR_FETCH_PERF_CNT_EN
      chk("table.count", fetch_count, 8);
`endif

      // Run off the end of memory: 120..128 are the last words.
      redirect    = 1'b1;
      redirect_pc = 120;
      step();
      chk("end.redir_addr", imem.imem_addr, 120);
      redirect = 1'b0;
      for (int i = 0; i < 8; i++) step();
      chk_all("end.pre", 128, mem_word(127), 128, 1, 0);
      stall = 1'b1;
      stall = 1'b0;
      step();
      chk_all("end.last", 129, mem_word(128), 129, 1, 1);
      stall = 1'b1;
      step();
      chk_all("end.stall", 129, mem_word(128), 129, 1, 1);
      stall = 1'b0;
      step();
      chk_all("end.bubble", 129, mem_word(128), 129, 0, 1);
      step();
      chk("end.hold_addr", imem.imem_addr, 129);
      redirect    = 1'b1;
      redirect_pc = 200;
      step();
      chk("done.r200_done", {31'd0, fetch_done}, 1);
      chk("done.r200_valid", {31'd0, if_id_valid}, 0);
      redirect_pc = 3;
      step();
      chk_all("done.r3", 3, 0, 129, 0, 0);
      redirect = 1'b0;
      step();
      chk_all("done.r3_cap", 4, mem_word(3), 4, 1, 0);

      // Asynchronous reset in the middle of fetching at pc=50.
      redirect    = 1'b1;
      redirect_pc = 45;
      step();
      redirect = 1'b0;
      for (int i = 0; i < 5; i++) step();
      chk_all("pre_rst", 50, mem_word(49), 50, 1, 0);
      #3;
      rst_n = 1'b0;
      #1;
      chk_all("async_rst", 0, 0, 0, 0, 0);
`ifdef INSTR_FETCH_PERF_CNT_EN
      chk("async_rst.count", fetch_count, 0);
`endif
      rst_n = 1'b1;
      step();
      chk_all("idle_after_rst", 0, 0, 0, 0, 0);

      // IDLE: redirect loads the PC but does not start fetching.
      redirect    = 1'b1;
      redirect_pc = 7;
      step();
      chk_all("idle.redir", 7, 0, 0, 0, 0);
      redirect = 1'b0;
      step();
      chk_all("idle.stay", 7, 0, 0, 0, 0);
      start       = 1'b1;
      redirect    = 1'b1;
      redirect_pc = 130;
      step();
      chk_all("idle.start_oor", 130, 0, 0, 0, 1);
      start    = 1'b0;
      redirect = 1'b0;

      #2;
      rst_n = 1'b0;
      #1;
      rst_n       = 1'b1;
      start       = 1'b1;
      redirect    = 1'b1;
      redirect_pc = 5;
      step();
      chk_all("idle.start_r5", 5, 0, 0, 0, 0);
      start    = 1'b0;
      redirect = 1'b0;
      step();
      chk_all("idle.r5_cap", 6, mem_word(5), 6, 1, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
